// File: rtl/egress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : egress_pkg
// Description : Shared types and default sizes for the egress arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package egress_pkg;

    localparam int SPL_W         = 16;
    localparam int PHIT_DEF      = 512;
    localparam int SIMD_DEF      = 16;
    localparam int HDR_BITS_DEF  = 272;
    localparam int CSUM_WAIT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_SPL  = 3'd1,
        ST_LOAD_HDR  = 3'd2,
        ST_WAIT_CSUM = 3'd3,
        ST_STREAM    = 3'd4,
        ST_FLUSH     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/egress_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first set request at or after
//               ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] w_pos;

    always_comb begin
        any   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(N)) begin
                w_pos = w_pos - (IDX_W+1)'(N);
            end
            if (!any && req[w_pos[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : egress_arbiter
// Description : Round-robin owner of the shared packet assembler: loads SPL and
//               header, waits out the checksum pipe, streams payload, flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_arbiter
    import egress_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PHIT      = PHIT_DEF,
    parameter int SIMD      = SIMD_DEF,
    parameter int HDR_BITS  = HDR_BITS_DEF,
    parameter int CSUM_WAIT = CSUM_WAIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ack,
    input  logic [NUM_REQ*SPL_W-1:0]    req_spl,
    input  logic [NUM_REQ*HDR_BITS-1:0] req_header,
    input  logic [NUM_REQ*PHIT-1:0]     s_tdata,
    input  logic [NUM_REQ*SIMD-1:0]     s_tvalid,
    input  logic [NUM_REQ*SIMD-1:0]     s_tlast,
    output logic [NUM_REQ-1:0]          s_tready,
    output logic                        asm_is_spl,
    output logic [31:0]                 asm_rf_in,
    output logic                        asm_is_header,
    output logic [HDR_BITS-1:0]         asm_header,
    output logic                        asm_is_vstreamout,
    output logic [PHIT-1:0]             asm_tdata,
    output logic [SIMD-1:0]             asm_tvalid,
    output logic [SIMD-1:0]             asm_tlast,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int         IDX_W       = $clog2(NUM_REQ);
    // r_cnt holds 0 on the first WAIT_CSUM cycle, so leaving at CSUM_WAIT-2
    // lands the first STREAM cycle CSUM_WAIT cycles after the header strobe.
    localparam logic [3:0] c_WAIT_LAST = 4'(CSUM_WAIT - 2);

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_win;
    logic [IDX_W-1:0]     r_ptr;
    logic [3:0]           r_cnt;
    logic                 r_seen;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_busy;
    logic                 r_is_spl;
    logic                 r_is_hdr;
    logic [SPL_W-1:0]     r_spl;
    logic [HDR_BITS-1:0]  r_hdr;

    logic                 w_any;
    logic [IDX_W-1:0]     w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_stream;
    logic                 w_beat;
    logic                 w_last;
    logic [PHIT-1:0]      w_tdata;
    logic [SIMD-1:0]      w_tvalid;
    logic [SIMD-1:0]      w_tlast;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    assign w_pick_oh = NUM_REQ'(1) << w_pick;

    // Zero-latency payload mux from the current owner.
    assign w_tdata  = s_tdata[r_win*PHIT +: PHIT];
    assign w_tvalid = s_tvalid[r_win*SIMD +: SIMD];
    assign w_tlast  = s_tlast[r_win*SIMD +: SIMD];
    assign w_stream = (r_state == ST_STREAM);
    assign w_beat   = w_stream & (|w_tvalid);
    assign w_last   = w_beat & (|w_tlast);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_any) w_next = ST_LOAD_SPL;
            ST_LOAD_SPL:  w_next = ST_LOAD_HDR;
            ST_LOAD_HDR:  w_next = ST_WAIT_CSUM;
            ST_WAIT_CSUM: if (r_cnt >= c_WAIT_LAST) w_next = ST_STREAM;
            ST_STREAM:    if (w_last) w_next = ST_FLUSH;
            ST_FLUSH:     w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_win    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_seen   <= 1'b0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
            r_is_spl <= 1'b0;
            r_is_hdr <= 1'b0;
            r_spl    <= '0;
            r_hdr    <= '0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != ST_IDLE);
            r_ack    <= '0;
            r_is_spl <= 1'b0;
            r_is_hdr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win    <= w_pick;
                        r_grant  <= w_pick_oh;
                        r_ack    <= w_pick_oh;
                        r_is_spl <= 1'b1;
                        r_spl    <= req_spl[w_pick*SPL_W +: SPL_W];
                        r_hdr    <= req_header[w_pick*HDR_BITS +: HDR_BITS];
                    end
                end
                ST_LOAD_SPL: r_is_hdr <= 1'b1;
                ST_LOAD_HDR: begin
                    r_cnt  <= '0;
                    r_seen <= 1'b0;
                end
                ST_WAIT_CSUM: if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
                ST_STREAM:    if (w_beat) r_seen <= 1'b1;
                ST_FLUSH: begin
                    r_grant <= '0;
                    r_ptr   <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ack           = r_ack;
    assign grant             = r_grant;
    assign busy              = r_busy;
    assign asm_is_spl        = r_is_spl;
    assign asm_rf_in         = {16'b0, r_spl};
    assign asm_is_header     = r_is_hdr;
    assign asm_header        = r_hdr;
    // FLUSH and every non-STREAM state drive an all-zero payload.
    assign asm_is_vstreamout = w_beat & ~r_seen;
    assign asm_tdata         = w_stream ? w_tdata  : '0;
    assign asm_tvalid        = w_stream ? w_tvalid : '0;
    assign asm_tlast         = w_stream ? w_tlast  : '0;
    assign s_tready          = w_stream ? r_grant  : '0;

endmodule
`default_nettype wire
